pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 82 ++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register carrying payload, pc, destination, write-enable and Tnew,
// with stall/flush control and a saturating count of bubbles loaded since reset.
module pipe_stage_reg #(
    parameter int          PAYLOAD_W        = 64,
    parameter int          TNEW_W           = 2,
    parameter bit          DEC_TNEW         = 1'b1,
    parameter bit          KEEP_PC_ON_FLUSH = 1'b1,
    parameter logic [31:0] RESET_PC         = 32'h0000_3000,
    parameter int          CNT_W            = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall_in,
    input  logic                 flush_in,
    input  logic                 in_valid,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [31:0]          in_pc,
    input  logic [4:0]           in_a3,
    input  logic                 in_regwe,
    input  logic [TNEW_W-1:0]    in_tnew,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [31:0]          out_pc,
    output logic [4:0]           out_a3,
    output logic                 out_regwe,
    output logic [TNEW_W-1:0]    out_tnew,
    output logic [CNT_W-1:0]     bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                 wr_gate;
    logic [TNEW_W-1:0]    tnew_load;
    logic [CNT_W-1:0]     bubble_cnt_inc;

    assign wr_gate = in_valid & in_regwe;

    always_comb begin
        tnew_load = '0;
        if (in_valid) begin
            if (DEC_TNEW) begin
                tnew_load = (in_tnew == '0) ? '0 : in_tnew - TNEW_W'(1);
            end else begin
                tnew_load = in_tnew;
            end
        end
    end

    // Saturate rather than wrap so a long-running count never looks small again.
    assign bubble_cnt_inc = (bubble_cnt == CNT_MAX) ? bubble_cnt : bubble_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_payload <= '0;
            out_pc      <= RESET_PC;
            out_a3      <= '0;
            out_regwe   <= 1'b0;
            out_tnew    <= '0;
            bubble_cnt  <= '0;
        end else if (flush_in) begin
            out_valid   <= 1'b0;
            out_payload <= '0;
            out_pc      <= KEEP_PC_ON_FLUSH ? in_pc : 32'h0;
            out_a3      <= '0;
            out_regwe   <= 1'b0;
            out_tnew    <= '0;
            bubble_cnt  <= bubble_cnt_inc;
        end else if (!stall_in) begin
            out_valid   <= in_valid;
            out_payload <= in_valid ? in_payload : '0;
            out_pc      <= in_pc;
            out_a3      <= wr_gate ? in_a3 : '0;
            out_regwe   <= wr_gate;
            out_tnew    <= tnew_load;
            if (!in_valid) begin
                bubble_cnt <= bubble_cnt_inc;
            end
        end
    end

endmodule
